tc_banked_ram: RTL and testbench

TC_BANKED_RAM -- requirements
Module: tc_banked_ram

---
 rtl/tc_ram_pkg.sv | 15 +
 rtl/tc_ram_clear_seq.sv | 47 ++++
 rtl/tc_banked_ram.sv | 105 ++++++++++
 tb/tb_tc_banked_ram.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/tc_ram_pkg.sv
// Shared constants and types for the byte-lane banked RAM and its clear sequencer.
package tc_ram_pkg;

  localparam int LANE_W         = 64;
  localparam int BYTES_PER_LANE = 8;

  localparam int RD_OLD = 0;
  localparam int RD_NEW = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/tc_ram_clear_seq.sv
// Post-reset clear sweep: walks every word once, holding busy until the last one is zeroed.
module tc_ram_clear_seq
  import tc_ram_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          o_clr_en,
  output logic [AW-1:0] o_clr_addr,
  output logic          o_busy
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_e    r_state;
  logic [AW-1:0] r_clr_addr;
  logic          r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_clr_en   = (r_state == ST_CLEAR);
  assign o_clr_addr = r_clr_addr;
  assign o_busy     = r_busy;

endmodule

// File: rtl/tc_banked_ram.sv
// Single-port byte-maskable RAM, LANES x 64-bit wide, 1-cycle registered read,
// with a full-array zero sweep after every reset.
module tc_banked_ram
  import tc_ram_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int DEPTH   = 256,
  parameter int RD_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      save,
  input  logic [15:0]               address,
  input  logic [LANES*8-1:0]        wr_mask,
  input  logic [LANES*LANE_W-1:0]   in,
  output logic [LANES*LANE_W-1:0]   out,
  output logic                      out_valid,
  output logic                      busy
);

  localparam int DW = LANES * LANE_W;
  localparam int NB = LANES * BYTES_PER_LANE;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_out;
  logic          r_out_valid;

  logic          w_seq_clr_en;
  logic [AW-1:0] w_clr_addr;
  logic          w_busy;

  tc_ram_clear_seq #(.DEPTH(DEPTH)) u_clr (
    .clk        (clk),
    .rst        (rst),
    .o_clr_en   (w_seq_clr_en),
    .o_clr_addr (w_clr_addr),
    .o_busy     (w_busy)
  );

  logic          w_accept;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic [DW-1:0] w_rd_word;
  logic [DW-1:0] w_new_word;

  // rst gates requests directly since busy only rises on the edge that samples it
  assign w_accept   = !rst && !w_busy;
  assign w_in_range = ({1'b0, address} < DEPTH_L);
  assign w_idx      = address[AW-1:0];
  assign w_rd_word  = r_mem[w_idx];

  always_comb begin
    w_new_word = w_rd_word;
    for (int k = 0; k < NB; k++) begin
      if (save && wr_mask[k]) w_new_word[k*8 +: 8] = in[k*8 +: 8];
    end
  end

  // Single write port shared by the clear sweep and user saves
  logic [NB-1:0] w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;

  always_comb begin
    w_we    = '0;
    w_waddr = w_idx;
    w_wdata = in;
    if (w_seq_clr_en && !rst) begin
      w_we    = '1;
      w_waddr = w_clr_addr;
      w_wdata = '0;
    end else if (w_accept && save && w_in_range) begin
      w_we = wr_mask;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (w_we[k]) r_mem[w_waddr][k*8 +: 8] <= w_wdata[k*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !(w_accept && load)) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b1;
      if (!w_in_range)
        r_out <= '0;
      else if (RD_MODE == RD_NEW)
        r_out <= w_new_word;
      else
        r_out <= w_rd_word;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = w_busy;

endmodule

// File: tb/tb_tc_banked_ram.sv
// Bench for tc_banked_ram: read-first and write-first instances driven in lockstep,
// checked against an array-based memory model plus directed vector table.
module tb_tc_banked_ram;

  localparam int LANES = 2;
  localparam int DEPTH = 16;
  localparam int DW    = LANES * 64;
  localparam int NB    = LANES * 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load = 1'b0;
  logic            save = 1'b0;
  logic [15:0]     address = '0;
  logic [NB-1:0]   wr_mask = '0;
  logic [DW-1:0]   in = '0;
  logic [DW-1:0]   out_o, out_n;
  logic            v_o, v_n, b_o, b_n;

  always #5 clk = ~clk;

  tc_banked_ram #(.LANES(LANES), .DEPTH(DEPTH), .RD_MODE(0)) u_old (
    .clk(clk), .rst(rst), .load(load), .save(save), .address(address),
    .wr_mask(wr_mask), .in(in), .out(out_o), .out_valid(v_o), .busy(b_o)
  );

  tc_banked_ram #(.LANES(LANES), .DEPTH(DEPTH), .RD_MODE(1)) u_new (
    .clk(clk), .rst(rst), .load(load), .save(save), .address(address),
    .wr_mask(wr_mask), .in(in), .out(out_n), .out_valid(v_n), .busy(b_n)
  );

  int checks = 0;
  int errors = 0;

  // Reference: word array plus remaining busy cycles after reset
  logic [DW-1:0] m_mem [DEPTH];
  int            busy_left = 0;
  logic          e_valid, e_busy;
  logic [DW-1:0] e_old, e_new;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic ld, input logic sv, input logic [15:0] a,
                     input logic [NB-1:0] m, input logic [DW-1:0] d);
    logic          acc, inr;
    logic [DW-1:0] old, mrg;
    rst = r; load = ld; save = sv; address = a; wr_mask = m; in = d;
    acc = !r && (busy_left == 0);
    inr = (a < DEPTH);
    old = inr ? m_mem[a[3:0]] : '0;
    mrg = old;
    for (int k = 0; k < NB; k++)
      if (sv && m[k]) mrg[k*8 +: 8] = d[k*8 +: 8];
    if (!inr) mrg = '0;
    e_valid = acc && ld;
    e_old   = e_valid ? old : '0;
    e_new   = e_valid ? mrg : '0;
    if (acc && sv && inr) m_mem[a[3:0]] = mrg;
    if (r) begin
      busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    e_busy = (busy_left > 0);
    @(posedge clk); #1;
    chk("valid_rdold", DW'(v_o), DW'(e_valid));
    chk("valid_rdnew", DW'(v_n), DW'(e_valid));
    chk("busy_rdold",  DW'(b_o), DW'(e_busy));
    chk("busy_rdnew",  DW'(b_n), DW'(e_busy));
    chk("out_rdold",   out_o, e_old);
    chk("out_rdnew",   out_n, e_new);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  typedef struct {
    logic          ld, sv;
    logic [15:0]   a;
    logic [NB-1:0] m;
    logic [DW-1:0] d;
    logic          ev;
    logic [DW-1:0] eo, en;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int n;
    logic [DW-1:0] ones;
    ones = '1;
    tbl[0] = '{1'b0, 1'b1, 16'd3,  16'h000F, ones,        1'b0, '0, '0};
    tbl[1] = '{1'b1, 1'b0, 16'd3,  16'h0000, '0,          1'b1,
               128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF,
               128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF};
    tbl[2] = '{1'b0, 1'b1, 16'd5,  16'h0001, 128'h11,     1'b0, '0, '0};
    tbl[3] = '{1'b1, 1'b1, 16'd5,  16'h0001, 128'h22,     1'b1, 128'h11, 128'h22};
    tbl[4] = '{1'b1, 1'b0, 16'd5,  16'h0000, '0,          1'b1, 128'h22, 128'h22};
    tbl[5] = '{1'b0, 1'b1, 16'd4,  16'h0001, 128'h77,     1'b0, '0, '0};
    tbl[6] = '{1'b0, 1'b1, 16'd20, 16'hFFFF, {16{8'hAB}}, 1'b0, '0, '0};
    tbl[7] = '{1'b1, 1'b0, 16'd20, 16'h0000, '0,          1'b1, '0, '0};
    tbl[8] = '{1'b1, 1'b0, 16'd4,  16'h0000, '0,          1'b1, 128'h77, 128'h77};
    tbl[9] = '{1'b1, 1'b0, 16'd3,  16'h0000, '0,          1'b1,
               128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF,
               128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF};

    // Power-up reset and sweep; requests issued while busy must be dropped
    n = 0;
    cyc(1'b1, 1'b1, 1'b1, 16'd2, '1, rnd_word());
    while (b_o && n < 40) begin
      n++;
      cyc(1'b0, 1'b1, 1'b1, 16'd1, '1, rnd_word());
    end
    chk("sweep_len", DW'(n), DW'(DEPTH));
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 1'b0, 16'(i), '0, '0);

    // Directed vectors: masking, collision, out of range
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, tbl[i].ld, tbl[i].sv, tbl[i].a, tbl[i].m, tbl[i].d);
      chk($sformatf("tbl%0d_valid", i), DW'(v_o), DW'(tbl[i].ev));
      chk($sformatf("tbl%0d_rdold", i), out_o, tbl[i].eo);
      chk($sformatf("tbl%0d_rdnew", i), out_n, tbl[i].en);
    end

    // Back-to-back saves then loads with no gaps
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 16'(i + 8), '1, rnd_word());
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'(i + 8), '0, '0);
      if (v_o && v_n) n++;
    end
    chk("b2b_valid_run", DW'(n), DW'(8));

    // Reset again partway through the sweep; busy restarts from the second reset
    cyc(1'b1, 1'b0, 1'b0, 16'd0, '0, '0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b1, 16'(i), '1, rnd_word());
    n = 0;
    cyc(1'b1, 1'b1, 1'b1, 16'd9, '1, rnd_word());
    while (b_o && n < 40) begin
      n++;
      cyc(1'b0, 1'b1, 1'b1, 16'(n % DEPTH), '1, rnd_word());
    end
    chk("resweep_len", DW'(n), DW'(DEPTH));
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 1'b0, 16'(i), '0, '0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 149) == 0), 1'($urandom()), 1'($urandom()),
          16'($urandom_range(0, 21)), NB'($urandom()), rnd_word());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
